// File: rtl/uart_txrx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_txrx
//  Description : 8N1 UART transmitter and receiver sharing one clock and
//                reset, no FIFO. LSB first, one start bit, one stop bit.
//                Optional macro UART_RX_SYNC_EN adds a 2-flop synchronizer
//                ahead of the receive sampling flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_txrx #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       i_Clock,
    input  logic       i_Resetn,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_bit_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half_bit = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_START   = 3'd1,
        TX_DATA    = 3'd2,
        TX_STOP    = 3'd3,
        TX_CLEANUP = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_CLEANUP = 3'd4
    } rx_state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t        r_tx_state, w_tx_state_nxt;
    logic [CNT_W-1:0] r_tx_cnt,   w_tx_cnt_nxt;
    logic [2:0]       r_tx_idx,   w_tx_idx_nxt;
    logic [7:0]       r_tx_byte,  w_tx_byte_nxt;
    logic             r_tx_active, w_tx_active_nxt;
    logic             r_tx_serial, w_tx_serial_nxt;
    logic             r_tx_done,   w_tx_done_nxt;
    logic [2:0]       w_tx_idx_inc;

    assign w_tx_idx_inc = r_tx_idx + 3'd1;

    // TX state and output registers; line idles high out of reset
    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            r_tx_state  <= TX_IDLE;
            r_tx_cnt    <= '0;
            r_tx_idx    <= 3'd0;
            r_tx_byte   <= 8'h00;
            r_tx_active <= 1'b0;
            r_tx_serial <= 1'b1;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_state  <= w_tx_state_nxt;
            r_tx_cnt    <= w_tx_cnt_nxt;
            r_tx_idx    <= w_tx_idx_nxt;
            r_tx_byte   <= w_tx_byte_nxt;
            r_tx_active <= w_tx_active_nxt;
            r_tx_serial <= w_tx_serial_nxt;
            r_tx_done   <= w_tx_done_nxt;
        end
    end

    // TX next state; the line value is computed one cycle ahead so the pin is a flop
    always_comb begin
        w_tx_state_nxt  = r_tx_state;
        w_tx_cnt_nxt    = r_tx_cnt;
        w_tx_idx_nxt    = r_tx_idx;
        w_tx_byte_nxt   = r_tx_byte;
        w_tx_active_nxt = r_tx_active;
        w_tx_serial_nxt = r_tx_serial;
        w_tx_done_nxt   = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_serial_nxt = 1'b1;
                w_tx_active_nxt = 1'b0;
                w_tx_cnt_nxt    = '0;
                w_tx_idx_nxt    = 3'd0;
                if (i_Tx_DV) begin
                    w_tx_byte_nxt   = i_Tx_Byte;
                    w_tx_active_nxt = 1'b1;
                    w_tx_serial_nxt = 1'b0;
                    w_tx_state_nxt  = TX_START;
                end
            end
            TX_START: begin
                if (r_tx_cnt == c_bit_last) begin
                    w_tx_cnt_nxt    = '0;
                    w_tx_serial_nxt = r_tx_byte[0];
                    w_tx_state_nxt  = TX_DATA;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + c_cnt_one;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == c_bit_last) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_idx == 3'd7) begin
                        w_tx_serial_nxt = 1'b1;
                        w_tx_state_nxt  = TX_STOP;
                    end else begin
                        w_tx_idx_nxt    = w_tx_idx_inc;
                        w_tx_serial_nxt = r_tx_byte[w_tx_idx_inc];
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + c_cnt_one;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == c_bit_last) begin
                    w_tx_cnt_nxt    = '0;
                    w_tx_active_nxt = 1'b0;
                    w_tx_done_nxt   = 1'b1;
                    w_tx_state_nxt  = TX_CLEANUP;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + c_cnt_one;
                end
            end
            TX_CLEANUP: begin
                w_tx_state_nxt = TX_IDLE;
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    assign o_Tx_Active = r_tx_active;
    assign o_Tx_Serial = r_tx_serial;
    assign o_Tx_Done   = r_tx_done;

    // ------------------------------------------------------------------
    // Receiver input conditioning
    // ------------------------------------------------------------------
    logic r_rx_s;

`ifdef UART_RX_SYNC_EN
    logic r_rx_meta;
    logic r_rx_sync;

    // Two synchronizer stages plus the sampling flop; all idle high
    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_Rx_Serial;
            r_rx_sync <= r_rx_meta;
            r_rx_s    <= r_rx_sync;
        end
    end
`else
    // Single sampling flop on the asynchronous line, idle high
    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            r_rx_s <= 1'b1;
        end else begin
            r_rx_s <= i_Rx_Serial;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t        r_rx_state, w_rx_state_nxt;
    logic [CNT_W-1:0] r_rx_cnt,   w_rx_cnt_nxt;
    logic [2:0]       r_rx_idx,   w_rx_idx_nxt;
    logic [7:0]       r_rx_shift, w_rx_shift_nxt;
    logic [7:0]       r_rx_byte,  w_rx_byte_nxt;
    logic             r_rx_dv,    w_rx_dv_nxt;

    // RX state and output registers
    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_byte  <= 8'h00;
            r_rx_dv    <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_idx   <= w_rx_idx_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_byte  <= w_rx_byte_nxt;
            r_rx_dv    <= w_rx_dv_nxt;
        end
    end

    // RX next state; output byte only updates on a frame with a good stop bit
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_idx_nxt   = r_rx_idx;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_byte_nxt  = r_rx_byte;
        w_rx_dv_nxt    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = '0;
                w_rx_idx_nxt = 3'd0;
                if (!r_rx_s) begin
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt == c_half_bit) begin
                    w_rx_cnt_nxt = '0;
                    // A start bit that is gone by mid-bit was a glitch
                    w_rx_state_nxt = r_rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_cnt_one;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nxt             = '0;
                    w_rx_shift_nxt[r_rx_idx] = r_rx_s;
                    if (r_rx_idx == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_rx_idx_nxt = r_rx_idx + 3'd1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_cnt_one;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_rx_byte_nxt = r_rx_shift;
                        w_rx_dv_nxt   = 1'b1;
                    end
                    w_rx_state_nxt = RX_CLEANUP;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_cnt_one;
                end
            end
            RX_CLEANUP: begin
                w_rx_state_nxt = RX_IDLE;
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    assign o_Rx_DV   = r_rx_dv;
    assign o_Rx_Byte = r_rx_byte;

endmodule
`default_nettype wire

// File: tb/tb_uart_txrx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_txrx
//  Description : Directed self-checking bench for uart_txrx, CLKS_PER_BIT=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_txrx;

    localparam int CPB = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tx_dv    = 1'b0;
    logic [7:0] tx_byte  = 8'h00;
    logic       tx_active;
    logic       tx_serial;
    logic       tx_done;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       loopback = 1'b0;
    logic       rx_drive = 1'b1;
    logic       rx_in;

    int         vectors     = 0;
    int         miscompares = 0;
    int         dv_count    = 0;
    int         done_count  = 0;
    logic [7:0] dv_byte     = 8'h00;

    assign rx_in = loopback ? tx_serial : rx_drive;

    uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Resetn    (rst_n),
        .i_Tx_DV     (tx_dv),
        .i_Tx_Byte   (tx_byte),
        .o_Tx_Active (tx_active),
        .o_Tx_Serial (tx_serial),
        .o_Tx_Done   (tx_done),
        .i_Rx_Serial (rx_in),
        .o_Rx_DV     (rx_dv),
        .o_Rx_Byte   (rx_byte)
    );

    always #5 clk = ~clk;

    // Pulse counters and last received byte, sampled on the falling edge
    always @(negedge clk) begin
        if (rx_dv) begin
            dv_count++;
            dv_byte = rx_byte;
        end
        if (tx_done) done_count++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        tx_byte = b;
        tx_dv   = 1'b1;
        tick(1);
        tx_dv   = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !tx_done; i++) tick(1);
        tick(5);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        rx_drive = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_drive = b[i];
            tick(CPB);
        end
        rx_drive = stop_bit;
        tick(CPB);
        rx_drive = 1'b1;
    endtask

    initial begin
        logic [9:0] exp_frame;
        logic [7:0] vals [3];
        int act_cnt;
        int done_seen;
        int done_at;
        int prev_dv;
        int prev_done;

        // 1: reset values
        tick(3);
        check("reset_tx_serial", tx_serial, 1);
        check("reset_tx_active", tx_active, 0);
        check("reset_tx_done",   tx_done,   0);
        check("reset_rx_dv",     rx_dv,     0);
        check("reset_rx_byte",   rx_byte,   8'h00);
        rst_n = 1'b1;
        tick(2);

        // 2: TX 0xA5 waveform, busy window, dropped second strobe
        exp_frame = 10'b1_1010_0101_0;
        act_cnt   = 0;
        done_seen = 0;
        done_at   = 0;
        prev_done = done_count;
        send(8'hA5);
        for (int i = 1; i <= 100; i++) begin
            if (tx_active) act_cnt++;
            if (tx_done) begin
                done_seen++;
                done_at = i;
            end
            if ((i % 8) == 4 && i <= 76)
                check($sformatf("tx_a5_bit%0d", (i - 4) / 8), tx_serial, exp_frame[(i - 4) / 8]);
            if (i == 20) begin
                tx_byte = 8'h3C;
                tx_dv   = 1'b1;
            end
            if (i == 21) tx_dv = 1'b0;
            tick(1);
        end
        check("tx_active_cycles", act_cnt,   80);
        check("tx_done_pulses",   done_seen, 1);
        check("tx_done_cycle",    done_at,   81);
        tick(20);
        check("tx_dropped_active", tx_active, 0);
        check("tx_dropped_line",   tx_serial, 1);
        check("tx_dropped_done",   done_count - prev_done, 1);

        // 3: loopback 0x00, 0xFF, 0x5A
        loopback = 1'b1;
        vals = '{8'h00, 8'hFF, 8'h5A};
        for (int k = 0; k < 3; k++) begin
            prev_dv = dv_count;
            send(vals[k]);
            wait_done(200);
            check($sformatf("loop_dv_%02h", vals[k]),   dv_count - prev_dv, 1);
            check($sformatf("loop_byte_%02h", vals[k]), dv_byte, vals[k]);
        end

        // 4: short low glitch, then a good frame 0x81
        loopback = 1'b0;
        tick(5);
        prev_dv  = dv_count;
        rx_drive = 1'b0;
        tick(2);
        rx_drive = 1'b1;
        tick(30);
        check("glitch_no_dv", dv_count - prev_dv, 0);
        drive_frame(8'h81, 1'b1);
        tick(10);
        check("after_glitch_dv",   dv_count - prev_dv, 1);
        check("after_glitch_byte", rx_byte, 8'h81);

        // 5: framing error on 0x42
        prev_dv = dv_count;
        drive_frame(8'h42, 1'b0);
        tick(30);
        check("framing_no_dv",  dv_count - prev_dv, 0);
        check("framing_hold",   rx_byte, 8'h81);

        // 7: back-to-back frames with the strobe held high
        loopback  = 1'b1;
        prev_dv   = dv_count;
        prev_done = done_count;
        tx_byte   = 8'h3C;
        tx_dv     = 1'b1;
        tick(100);
        tx_dv     = 1'b0;
        tick(200);
        check("b2b_done", done_count - prev_done, 2);
        check("b2b_dv",   dv_count - prev_dv, 2);
        check("b2b_byte", rx_byte, 8'h3C);

        // 6: reset during TX/RX bit 3, then 0x99
        prev_dv   = dv_count;
        prev_done = done_count;
        send(8'hF0);
        tick(35);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_serial", tx_serial, 1);
        check("midrst_tx_active", tx_active, 0);
        check("midrst_rx_dv",     rx_dv,     0);
        check("midrst_rx_byte",   rx_byte,   8'h00);
        tick(4);
        rst_n = 1'b1;
        tick(100);
        check("midrst_no_done", done_count - prev_done, 0);
        check("midrst_no_dv",   dv_count - prev_dv, 0);
        send(8'h99);
        wait_done(200);
        check("post_rst_done", done_count - prev_done, 1);
        check("post_rst_dv",   dv_count - prev_dv, 1);
        check("post_rst_byte", rx_byte, 8'h99);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
